// File: rtl/dp_out_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dp_out_monitor
// Description : Display-side reader for the datapath output bus. Captures
//               distinct datapath_out values (with their Z_out flag) into a
//               small circular history, lets the user step through it with
//               two push-buttons, and drives active-low seven-segment digits
//               plus status LEDs from registered outputs.
// Options     : define LEADING_ZERO_BLANK_EN to blank leading zero digits on
//               hex3..hex1 (hex0 is always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module dp_out_monitor #(
    parameter int DEPTH = 4,    // history entries, power of two, 2..8
    parameter int W     = 16    // datapath word width, four hex digits
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] datapath_out,
    input  logic         Z_out,
    input  logic         cap_en,
    input  logic         key_older_n,
    input  logic         key_newer_n,
    output logic [6:0]   hex0,
    output logic [6:0]   hex1,
    output logic [6:0]   hex2,
    output logic [6:0]   hex3,
    output logic [6:0]   hex4,
    output logic [6:0]   hex5,
    output logic         ledr_z,
    output logic [3:0]   ledr_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    // Hex digit to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // History storage: each entry is {Z, value}.
    logic [W:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] view;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] newest_idx;
    logic [PTR_W-1:0] view_idx;
    logic [W:0]       view_entry;
    logic             capture;

    // Key synchronizers (s1, s2) and edge-detect history (s3).
    logic older_s1, older_s2, older_s3;
    logic newer_s1, newer_s2, newer_s3;
    logic older_pulse, newer_pulse;

    // Digit patterns computed from the current state, registered below.
    logic [6:0] dig0, dig1, dig2, dig3;

    // The newest entry sits just behind the write pointer; the view index
    // counts backwards from it. Power-of-two depth makes the wrap free.
    assign newest_idx = wr_ptr - PTR_W'(1);
    assign view_idx   = newest_idx - view;
    assign view_entry = mem[view_idx];

    // Only store values that differ from the newest one so a static bus
    // does not flood the history. The count check keeps the comparison
    // against stale memory out of the decision on an empty buffer.
    assign capture = cap_en &&
                     ((count == '0) || (datapath_out != mem[newest_idx][W-1:0]));

    // Single-cycle pulse on the released-to-pressed transition.
    assign older_pulse = older_s3 & ~older_s2;
    assign newer_pulse = newer_s3 & ~newer_s2;

    // The blank digit never changes.
    assign hex4 = SEG_BLANK;

    // History write port; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= {Z_out, datapath_out};
        end
    end

    // Synchronize the raw push-buttons; released (1) is the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older_s1 <= 1'b1;
            older_s2 <= 1'b1;
            older_s3 <= 1'b1;
            newer_s1 <= 1'b1;
            newer_s2 <= 1'b1;
            newer_s3 <= 1'b1;
        end else begin
            older_s1 <= key_older_n;
            older_s2 <= older_s1;
            older_s3 <= older_s2;
            newer_s1 <= key_newer_n;
            newer_s2 <= newer_s1;
            newer_s3 <= newer_s2;
        end
    end

    // Buffer bookkeeping and view navigation; a capture always returns
    // the view to the live (newest) entry and takes priority over keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
            view   <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (count != CNT_FULL) begin
                    count <= count + CNT_W'(1);
                end
                view <= '0;
            end else if (count == '0) begin
                view <= '0;
            end else if (older_pulse && !newer_pulse) begin
                if ((CNT_W'(view) + CNT_W'(1)) < count) begin
                    view <= view + PTR_W'(1);
                end
            end else if (newer_pulse && !older_pulse) begin
                if (view != '0) begin
                    view <= view - PTR_W'(1);
                end
            end
        end
    end

    // Decode the viewed value into digits, optionally hiding leading zeros.
    always_comb begin
        dig0 = seg7(view_entry[3:0]);
        dig1 = seg7(view_entry[7:4]);
        dig2 = seg7(view_entry[11:8]);
        dig3 = seg7(view_entry[15:12]);
`ifdef LEADING_ZERO_BLANK_EN
        if (view_entry[15:12] == 4'h0) begin
            dig3 = SEG_BLANK;
        end
        if (view_entry[15:8] == 8'h00) begin
            dig2 = SEG_BLANK;
        end
        if (view_entry[15:4] == 12'h000) begin
            dig1 = SEG_BLANK;
        end
`else
        // All four digits are always shown.
`endif
    end

    // Register the display from the current state; it trails by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex0     <= SEG_BLANK;
            hex1     <= SEG_BLANK;
            hex2     <= SEG_BLANK;
            hex3     <= SEG_BLANK;
            hex5     <= SEG_BLANK;
            ledr_z   <= 1'b0;
            ledr_cnt <= 4'd0;
        end else if (count == '0) begin
            hex0     <= SEG_BLANK;
            hex1     <= SEG_BLANK;
            hex2     <= SEG_BLANK;
            hex3     <= SEG_BLANK;
            hex5     <= SEG_BLANK;
            ledr_z   <= 1'b0;
            ledr_cnt <= 4'd0;
        end else begin
            hex0     <= dig0;
            hex1     <= dig1;
            hex2     <= dig2;
            hex3     <= dig3;
            hex5     <= seg7(4'(view));
            ledr_z   <= view_entry[W];
            ledr_cnt <= 4'(count);
        end
    end

endmodule
`default_nettype wire
